c3po_sched: RTL
===============

C3PO_SCHED -- requirements
Module: c3po_sched

Interface
REQ-001 SHALL have parameter SRC_P, default 4, number of packet requesters sharing the c3po input.
REQ-002 SHALL have parameter PORTS_P, default 4, number of c3po output ports; power of two, at most 16.
REQ-003 SHALL have parameter CNT_SIZE_P, default 8, width of per-requester packet counters.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock.
REQ-005 SHALL have reset_L, input, 1, asynchronous active-low reset.
REQ-006 SHALL have src_sop / src_eop / src_val, input, [SRC_P-1:0], per-requester beat qualifiers.
REQ-007 SHALL have src_vbc, input, [SRC_P-1:0][7:0], valid byte count of the beat.
REQ-008 SHALL have src_id, input, [SRC_P-1:0][3:0], packet id; destination port = id[log2(PORTS_P)-1:0].
REQ-009 SHALL have src_data, input, [SRC_P-1:0][160*8-1:0], beat payload.
REQ-010 SHALL have src_rdy, output, [SRC_P-1:0], beat accepted when src_val & src_rdy.
REQ-011 SHALL have o_sop / o_eop / o_val, output, 1 each, beat qualifiers to c3po input.
REQ-012 SHALL have o_vbc [7:0], o_id [3:0] and o_data [160*8-1:0], outputs, forwarded beat fields.
REQ-013 SHALL have port_ready, input, [PORTS_P-1:0], c3po per-port ready.
REQ-014 SHALL have grant, output, [SRC_P-1:0], one-hot owner of the c3po input, zero when idle.
REQ-015 SHALL have pkt_cnt, output, [SRC_P-1:0][CNT_SIZE_P-1:0], completed packets per requester.
REQ-016 SHALL have err_drop and err_sop, outputs, 1 each, single-cycle protocol-error pulses.

Function
REQ-017 SHALL implement FSM with states IDLE and BUSY.
REQ-018 In IDLE, requester i SHALL be eligible when src_val[i] & src_sop[i] & port_ready[port(src_id[i])].
REQ-019 In IDLE, arbitration SHALL be round-robin, searching from rr_ptr upward with wrap to 0.
REQ-020 On a win, the SHALL set grant to one-hot i, set rr_ptr = (i+1) mod SRC_P, and enter BUSY next cycle; the sop beat is not consumed in IDLE.
REQ-021 In IDLE, a requester with src_val & !src_sop SHALL get src_rdy=1; the beat is discarded and err_drop pulses for one cycle (several such requesters in one cycle: one pulse).
REQ-022 In BUSY, src_rdy SHALL equal grant; all other src_rdy = 0.
REQ-023 Each accepted beat SHALL appear on o_* registered, exactly 1 cycle later, with o_val=1.
REQ-024 When src_val of the owner is low in BUSY, o_val SHALL be 0 next cycle and the FSM SHALL stay in BUSY.
REQ-025 An accepted owner beat with src_sop=1 in BUSY SHALL be forwarded unchanged and SHALL pulse err_sop; the FSM SHALL stay in BUSY.
REQ-026 An accepted owner beat with src_eop=1 SHALL return the FSM to IDLE and clear grant next cycle, and SHALL increment pkt_cnt[owner] modulo 2^CNT_SIZE_P.
REQ-027 A single-beat packet (sop & eop) SHALL be handled per REQ-026.
REQ-028 Minimum spacing SHALL be one idle arbitration cycle between packets.
REQ-029 port_ready SHALL be sampled only at arbitration; deassertion during BUSY SHALL NOT stall or abort.
REQ-030 When no requester is eligible, the block SHALL stay in IDLE, rr_ptr unchanged, and o_val = 0.
REQ-031 o_sop, o_eop, o_vbc, o_id and o_data SHALL be zero whenever o_val = 0.

Reset
REQ-032 On reset_L low, asynchronously: state IDLE, grant 0, rr_ptr 0, all o_* 0, src_rdy 0, pkt_cnt 0, err_* 0.
REQ-033 Reset mid-packet SHALL abandon the packet with no o_eop emitted and no pkt_cnt increment.

Structure
REQ-034 A package c3po_sched_pkg SHALL hold the state enum, the 160-byte input width constant and the port-index helper function.
REQ-035 The round-robin selector SHALL be a sub-module c3po_rr_arb (request vector, pointer -> one-hot grant, valid).

Verification
REQ-036 Reqs 0 and 2 both present single-beat packets every cycle, all ready -> grants alternate 0,2,0,2; pkt_cnt[0]=pkt_cnt[2] after 10 packets.
REQ-037 Req 1 sends a 3-beat packet id=5, vbc=160,160,40 -> o_id=5 on 3 consecutive o_val cycles 1 cycle after acceptance; o_eop with o_vbc=40; pkt_cnt[1]=1.
REQ-038 Req 3 sop with id=6, port_ready=4'b1011 -> no grant; raise port_ready[2] -> grant=4'b1000 next cycle.
REQ-039 Req 0 beat with val=1, sop=0 in IDLE -> src_rdy[0]=1, err_drop one pulse, o_val stays 0.
REQ-040 Reset asserted on beat 2 of a 4-beat packet -> all outputs 0 immediately; pkt_cnt=0; after release, arbitration restarts from req 0.
REQ-041 pkt_cnt[0] at 255 with CNT_SIZE_P=8, one more packet -> pkt_cnt[0]=0.

Source files
------------

// File: rtl/c3po_sched_pkg.sv
// c3po_sched shared types and helpers.
// State encoding, beat width and port decode.
package c3po_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DATA_BYTES = 160;
  localparam int DATA_W     = DATA_BYTES * 8;

  // Destination port is the low log2(ports) bits of the id.
  function automatic logic [3:0] port_idx(
    input logic [3:0] id,
    input int         ports
  );
    return id & 4'(ports - 1);
  endfunction

endpackage

// File: rtl/c3po_rr_arb.sv
// Round-robin selector: first request at or above ptr,
// wrapping to 0; one-hot grant plus valid.
module c3po_rr_arb #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  // Rotate so ptr sits at bit 0, take lowest set bit, rotate back.
  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    pick  = rot & (~rot + N'(1));
    back  = {pick, pick} << ptr;
    gnt   = back[2*N-1:N];
    valid = |req;
  end

endmodule

// File: rtl/c3po_sched.sv
// c3po input scheduler: arbitrates whole packets from
// several requesters onto one registered c3po beat stream.
module c3po_sched
  import c3po_sched_pkg::*;
#(
  parameter int SRC_P      = 4,
  parameter int PORTS_P    = 4,
  parameter int CNT_SIZE_P = 8
) (
  input  logic                                clk,
  input  logic                                reset_L,
  input  logic [SRC_P-1:0]                    src_sop,
  input  logic [SRC_P-1:0]                    src_eop,
  input  logic [SRC_P-1:0]                    src_val,
  input  logic [SRC_P-1:0][7:0]               src_vbc,
  input  logic [SRC_P-1:0][3:0]               src_id,
  input  logic [SRC_P-1:0][DATA_W-1:0]        src_data,
  output logic [SRC_P-1:0]                    src_rdy,
  output logic                                o_sop,
  output logic                                o_eop,
  output logic                                o_val,
  output logic [7:0]                          o_vbc,
  output logic [3:0]                          o_id,
  output logic [DATA_W-1:0]                   o_data,
  input  logic [PORTS_P-1:0]                  port_ready,
  output logic [SRC_P-1:0]                    grant,
  output logic [SRC_P-1:0][CNT_SIZE_P-1:0]    pkt_cnt,
  output logic                                err_drop,
  output logic                                err_sop
);

  localparam int PW = (SRC_P > 1) ? $clog2(SRC_P) : 1;

  state_e                           state;
  state_e                           state_n;
  logic [PW-1:0]                    rr_ptr;
  logic [PW-1:0]                    rr_ptr_n;
  logic [PW-1:0]                    win_ptr;
  logic [SRC_P-1:0]                 grant_n;
  logic [SRC_P-1:0]                 elig;
  logic [SRC_P-1:0]                 arb_gnt;
  logic                             arb_vld;
  logic                             first;
  logic                             first_n;
  logic [15:0]                      rdy16;

  logic                             sel_val;
  logic                             sel_sop;
  logic                             sel_eop;
  logic [7:0]                       sel_vbc;
  logic [3:0]                       sel_id;
  logic [DATA_W-1:0]                sel_data;

  logic                             val_n;
  logic                             sop_n;
  logic                             eop_n;
  logic [7:0]                       vbc_n;
  logic [3:0]                       id_n;
  logic [DATA_W-1:0]                data_n;
  logic [SRC_P-1:0][CNT_SIZE_P-1:0] cnt_n;
  logic                             drop_n;
  logic                             esop_n;

  assign rdy16 = 16'(port_ready);

  // A requester may win only with a sop beat to a ready port.
  always_comb begin
    elig = '0;
    for (int i = 0; i < SRC_P; i++)
      elig[i] = src_val[i] & src_sop[i]
              & rdy16[port_idx(src_id[i], PORTS_P)];
  end

  c3po_rr_arb #(
    .N  (SRC_P),
    .PW (PW)
  ) u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .valid (arb_vld)
  );

  // Pointer moves just past the winner; last requester wraps to 0.
  always_comb begin
    win_ptr = '0;
    for (int i = 0; i < SRC_P - 1; i++)
      if (arb_gnt[i]) win_ptr = PW'(i + 1);
  end

  // Pick the owner's beat fields.
  always_comb begin
    sel_val  = 1'b0;
    sel_sop  = 1'b0;
    sel_eop  = 1'b0;
    sel_vbc  = '0;
    sel_id   = '0;
    sel_data = '0;
    for (int i = 0; i < SRC_P; i++) begin
      if (grant[i]) begin
        sel_val  = src_val[i];
        sel_sop  = src_sop[i];
        sel_eop  = src_eop[i];
        sel_vbc  = src_vbc[i];
        sel_id   = src_id[i];
        sel_data = src_data[i];
      end
    end
  end

  // Idle flushes stray non-sop beats; busy takes only the owner.
  assign src_rdy = !reset_L       ? '0 :
                   (state == IDLE) ? (src_val & ~src_sop) :
                                     grant;

  // Next state, grant, forwarded beat, counters and error pulses.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    rr_ptr_n = rr_ptr;
    first_n  = first;
    cnt_n    = pkt_cnt;
    val_n    = 1'b0;
    sop_n    = 1'b0;
    eop_n    = 1'b0;
    vbc_n    = '0;
    id_n     = '0;
    data_n   = '0;
    drop_n   = 1'b0;
    esop_n   = 1'b0;
    unique case (state)
      IDLE: begin
        drop_n = |(src_val & ~src_sop);
        if (arb_vld) begin
          state_n  = BUSY;
          grant_n  = arb_gnt;
          rr_ptr_n = win_ptr;
          first_n  = 1'b1;
        end
      end
      BUSY: begin
        if (sel_val) begin
          val_n   = 1'b1;
          sop_n   = sel_sop;
          eop_n   = sel_eop;
          vbc_n   = sel_vbc;
          id_n    = sel_id;
          data_n  = sel_data;
          first_n = 1'b0;
          esop_n  = sel_sop & ~first;
          if (sel_eop) begin
            state_n = IDLE;
            grant_n = '0;
            for (int i = 0; i < SRC_P; i++)
              if (grant[i])
                cnt_n[i] = pkt_cnt[i] + CNT_SIZE_P'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_n;
  end

  // Ownership, output beat and status registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant    <= '0;
      rr_ptr   <= '0;
      first    <= 1'b0;
      o_val    <= 1'b0;
      o_sop    <= 1'b0;
      o_eop    <= 1'b0;
      o_vbc    <= '0;
      o_id     <= '0;
      o_data   <= '0;
      pkt_cnt  <= '0;
      err_drop <= 1'b0;
      err_sop  <= 1'b0;
    end else begin
      grant    <= grant_n;
      rr_ptr   <= rr_ptr_n;
      first    <= first_n;
      o_val    <= val_n;
      o_sop    <= sop_n;
      o_eop    <= eop_n;
      o_vbc    <= vbc_n;
      o_id     <= id_n;
      o_data   <= data_n;
      pkt_cnt  <= cnt_n;
      err_drop <= drop_n;
      err_sop  <= esop_n;
    end
  end

endmodule
